lc4_fetch_issue: RTL
====================

Name: lc4_fetch_issue

Overview:
- In-order, single-outstanding instruction sequencer that feeds lc4_alu.
- Fetches 20-bit instructions from instruction memory and resolves branch-class opcodes locally.
- Issues compute opcodes to the execute path via valid/ready, then waits for writeback before fetching again.
- Holds PC and NZP condition codes; the execute side never sees branch resolution.

Parameters:
- WORD_SIZE, 256, datapath width of writeback data
- INSN, 19, MSB index of instruction word (instruction is INSN+1 bits)
- IADDR, 10, MSB index of PC / instruction address (PC is IADDR+1 bits)

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- i_start  input  1  begin execution from PC 0; honoured only in IDLE or HALT
- o_imem_req  output  1  fetch request, held until i_imem_valid
- o_imem_addr  output  IADDR+1  fetch address (current PC)
- i_imem_valid  input  1  i_imem_insn valid this cycle
- i_imem_insn  input  INSN+1  fetched instruction
- o_issue_valid  output  1  o_insn/o_pc valid to execute path
- i_issue_ready  input  1  execute path accepts issue
- o_insn  output  INSN+1  issued instruction
- o_pc  output  IADDR+1  PC of issued instruction
- i_wb_valid  input  1  writeback of the outstanding instruction
- i_wb_data  input  WORD_SIZE  written-back result, used to set NZP
- o_nzp  output  3  condition codes {N,Z,P}
- o_retired  output  32  retired-instruction counter
- o_halted  output  1  high in HALT

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, nzp=3'b010, retired=0, insn_reg=0; all outputs deasserted or zero except o_nzp=010.
- Opcode = insn[19:15]. Branch class: 00000 NOP, 00001 BRz, 00010 BRzp, 00011 BRnp, 00100 BRnz, 01000 JSR. HALT = 11111. All other opcodes are compute.
- IDLE: on i_start go to FETCH with pc=0.
- FETCH: o_imem_req=1, o_imem_addr=pc. Address is stable while waiting; latency is arbitrary.
- On i_imem_valid in FETCH:
  - HALT: go to HALT, pc unchanged, retired unchanged.
  - Branch class: resolve in the same cycle.
    - taken: pc <= pc + sext(insn[8:0]) to IADDR+1 bits, mod 2^(IADDR+1).
    - not taken: pc <= pc+1, wrapping.
    - retired+1; stay in FETCH, so the request re-asserts next cycle with the new address.
    - Taken rules: NOP never; JSR always; BRz Z; BRzp Z|P; BRnp N|P; BRnz N|Z. Use nzp as held at capture.
  - Compute: insn_reg <= insn; go to ISSUE.
- ISSUE: o_issue_valid=1, o_insn=insn_reg, o_pc=pc. Both are stable until handshake. When valid & ready, go to WAIT_WB the next cycle.
- WAIT_WB: on i_wb_valid:
  - nzp <= N if i_wb_data[WORD_SIZE-1], else Z if i_wb_data==0, else P. Exactly one bit is set.
  - pc <= pc+1 (wrapping); retired+1; go to FETCH.
- i_wb_valid is ignored outside WAIT_WB. i_imem_valid is ignored outside FETCH. i_start is ignored in FETCH/ISSUE/WAIT_WB.
- HALT: o_halted=1. On i_start go to FETCH with pc=0 and nzp=010; retired is kept.
- PC wrap: pc=2^(IADDR+1)-1 increments to 0. A taken branch target wraps modulo 2^(IADDR+1).
- retired wraps at 2^32.
- Minimum latencies:
  - branch: 1 cycle per branch with zero-latency imem.
  - compute: FETCH→ISSUE→WAIT_WB→FETCH, 3 cycles minimum.

Test Plan:
- Reset then i_start: o_imem_req=1, o_imem_addr=0.
  - imem returns ADD (opcode 00101) → o_issue_valid=1, o_pc=0.
  - Hold ready low 3 cycles → o_insn stable.
  - i_wb_data=0 → o_nzp=010, retired=1, next addr=1.
- nzp=Z at pc=5, BRz with insn[8:0]=9'h1FC (-4) → next o_imem_addr=1, retired+1, no issue.
- nzp=P (wb_data=7), BRnz → not taken, next addr=pc+1.
- Wb data with MSB set → o_nzp=100. Then JSR with offset +3 at pc=2047 (IADDR=10) → addr wraps to 2.
- HALT fetched → o_halted=1, no o_imem_req. i_start → o_imem_addr=0, o_nzp=010, retired kept.
- rst asserted mid-WAIT_WB (asynchronous, between edges) → outputs zero immediately. A late i_wb_valid after rst is released is ignored (state IDLE).

Source files
------------

// File: rtl/lc4_fetch_issue.sv
// lc4_fetch_issue: in-order, single-outstanding instruction sequencer in
// front of lc4_alu. It fetches one instruction at a time and resolves
// branch-class opcodes locally against the held NZP codes. Compute opcodes
// are issued to the execute path, and the sequencer then waits for their
// writeback before fetching again.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   i_start                  start from PC 0 (honoured in IDLE / HALT only)
//   o_imem_req/o_imem_addr   fetch request, held with a stable address
//   i_imem_valid/i_imem_insn fetched instruction return
//   o_issue_valid/i_issue_ready, o_insn/o_pc  issue handshake to execute
//   i_wb_valid/i_wb_data     writeback of the outstanding instruction
//   o_nzp                    condition codes {N,Z,P}
//   o_retired                retired-instruction counter (wraps at 2^32)
//   o_halted                 high while in HALT
module lc4_fetch_issue #(
  parameter int WORD_SIZE = 256,
  parameter int INSN      = 19,
  parameter int IADDR     = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  output logic                 o_imem_req,
  output logic [IADDR:0]       o_imem_addr,
  input  logic                 i_imem_valid,
  input  logic [INSN:0]        i_imem_insn,
  output logic                 o_issue_valid,
  input  logic                 i_issue_ready,
  output logic [INSN:0]        o_insn,
  output logic [IADDR:0]       o_pc,
  input  logic                 i_wb_valid,
  input  logic [WORD_SIZE-1:0] i_wb_data,
  output logic [2:0]           o_nzp,
  output logic [31:0]          o_retired,
  output logic                 o_halted
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, WAIT_WB, HALT} state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_BRZ  = 5'b00001;
  localparam logic [4:0] OP_BRZP = 5'b00010;
  localparam logic [4:0] OP_BRNP = 5'b00011;
  localparam logic [4:0] OP_BRNZ = 5'b00100;
  localparam logic [4:0] OP_JSR  = 5'b01000;
  localparam logic [4:0] OP_HALT = 5'b11111;

  state_t          state;
  state_t          nxt_state;
  logic [IADDR:0]  pc;
  logic [2:0]      nzp;
  logic [31:0]     retired;
  logic [INSN:0]   insn_reg;
  logic            req_q;
  logic            issue_q;
  logic            halted_q;

  logic [4:0]             opcode;
  logic signed [IADDR:0]  br_off;
  logic [IADDR:0]         br_target;

  function automatic logic is_branch(input logic [4:0] op);
    return (op == OP_NOP) || (op == OP_BRZ) || (op == OP_BRZP) ||
           (op == OP_BRNP) || (op == OP_BRNZ) || (op == OP_JSR);
  endfunction

  // cc is {N,Z,P}
  function automatic logic br_taken(input logic [4:0] op, input logic [2:0] cc);
    case (op)
      OP_JSR:  return 1'b1;
      OP_BRZ:  return cc[1];
      OP_BRZP: return cc[1] | cc[0];
      OP_BRNP: return cc[2] | cc[0];
      OP_BRNZ: return cc[2] | cc[1];
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] nzp_of(input logic signed [WORD_SIZE-1:0] d);
    if (d < 0)       return 3'b100;
    else if (d == 0) return 3'b010;
    else             return 3'b001;
  endfunction

  assign opcode    = i_imem_insn[INSN:INSN-4];
  // 9-bit branch offset sign-extended to PC width; the add wraps mod 2^(IADDR+1)
  assign br_off    = signed'({{(IADDR-8){i_imem_insn[8]}}, i_imem_insn[8:0]});
  assign br_target = pc + br_off;

  always_comb begin
    nxt_state = state;
    case (state)
      IDLE:    if (i_start) nxt_state = FETCH;
      FETCH:   if (i_imem_valid) begin
                 if (opcode == OP_HALT)     nxt_state = HALT;
                 else if (is_branch(opcode)) nxt_state = FETCH;
                 else                        nxt_state = ISSUE;
               end
      ISSUE:   if (i_issue_ready) nxt_state = WAIT_WB;
      WAIT_WB: if (i_wb_valid) nxt_state = FETCH;
      HALT:    if (i_start) nxt_state = FETCH;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= '0;
      nzp      <= 3'b010;
      retired  <= '0;
      insn_reg <= '0;
      req_q    <= 1'b0;
      issue_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= nxt_state;
      req_q    <= (nxt_state == FETCH);
      issue_q  <= (nxt_state == ISSUE);
      halted_q <= (nxt_state == HALT);
      case (state)
        IDLE: if (i_start) pc <= '0;
        FETCH: if (i_imem_valid && opcode != OP_HALT) begin
          if (is_branch(opcode)) begin
            pc      <= br_taken(opcode, nzp) ? br_target : pc + 1'b1;
            retired <= retired + 32'd1;
          end else begin
            insn_reg <= i_imem_insn;
          end
        end
        WAIT_WB: if (i_wb_valid) begin
          nzp     <= nzp_of(i_wb_data);
          pc      <= pc + 1'b1;
          retired <= retired + 32'd1;
        end
        HALT: if (i_start) begin
          pc  <= '0;
          nzp <= 3'b010;
        end
        default: ;
      endcase
    end
  end

  assign o_imem_req    = req_q;
  assign o_imem_addr   = pc;
  assign o_issue_valid = issue_q;
  assign o_insn        = insn_reg;
  assign o_pc          = pc;
  assign o_nzp         = nzp;
  assign o_retired     = retired;
  assign o_halted      = halted_q;

endmodule
